// File: rtl/meas_shot_sched.sv
// meas_shot_sched: fires one element command a requested number of times,
// waits for the channel's done pulse after each shot, tallies the sign
// decisions and returns a single response record per request.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request
// ISSUE | command strobe cycle for one shot
// WAIT  | waiting for meas_done, optional timeout running
// CAP   | tally sign decisions (valid the cycle after done)
// GAP   | idle cycles between shots
// RESP  | response record presented until rsp_ready
module meas_shot_sched #(
  parameter int CNT_W = 12,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_cmd,
  input  logic [CNT_W-1:0] req_nshot,
  input  logic [15:0]      req_gap,
  input  logic [TMO_W-1:0] timeout,
  output logic [63:0]      command,
  output logic             cstrobe,
  input  logic             meas_done,
  input  logic             meas_resultx,
  input  logic             meas_resulty,
  input  logic [31:0]      meas_xacc,
  input  logic [31:0]      meas_yacc,
  input  logic             meas_collision,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] rsp_xones,
  output logic [CNT_W-1:0] rsp_yones,
  output logic [CNT_W-1:0] rsp_nshot,
  output logic [31:0]      rsp_xacc,
  output logic [31:0]      rsp_yacc,
  output logic [1:0]       rsp_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAP   = 3'd3,
    S_GAP   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] nshot_q;
  logic [15:0]      gap_q;
  logic [15:0]      gap_cnt;
  logic [TMO_W-1:0] wait_cnt;

  // Shot sequencer; the tallies double as the response record so they are
  // already registered and frozen while RESP waits for the consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      cstrobe   <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      command   <= '0;
      nshot_q   <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      wait_cnt  <= '0;
      rsp_xones <= '0;
      rsp_yones <= '0;
      rsp_nshot <= '0;
      rsp_xacc  <= '0;
      rsp_yacc  <= '0;
      rsp_err   <= '0;
    end else begin
      // Collision is sticky for the whole request but never aborts it.
      if ((state inside {S_ISSUE, S_WAIT, S_CAP, S_GAP}) && meas_collision)
        rsp_err[1] <= 1'b1;

      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            command   <= req_cmd;
            nshot_q   <= (req_nshot == '0) ? CNT_W'(1) : req_nshot;
            gap_q     <= req_gap;
            rsp_xones <= '0;
            rsp_yones <= '0;
            rsp_nshot <= '0;
            rsp_xacc  <= '0;
            rsp_yacc  <= '0;
            rsp_err   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cstrobe   <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          cstrobe  <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          wait_cnt <= wait_cnt + TMO_W'(1);
          if (meas_done) begin
            rsp_xacc <= meas_xacc;
            rsp_yacc <= meas_yacc;
            state    <= S_CAP;
          end else if ((timeout != '0) && (wait_cnt + TMO_W'(1) == timeout)) begin
            rsp_err[0] <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end

        S_CAP: begin
          rsp_xones <= rsp_xones + CNT_W'(meas_resultx);
          rsp_yones <= rsp_yones + CNT_W'(meas_resulty);
          rsp_nshot <= rsp_nshot + CNT_W'(1);
          if (rsp_nshot + CNT_W'(1) == nshot_q) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (gap_q == '0) begin
            cstrobe <= 1'b1;
            state   <= S_ISSUE;
          end else begin
            gap_cnt <= gap_q;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == 16'd1) begin
            cstrobe <= 1'b1;
            state   <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_meas_shot_sched.sv
// tb_meas_shot_sched: randomized bench for meas_shot_sched with a channel
// responder and a shot-level reference model of timing and tallies.
module tb_meas_shot_sched;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [63:0] req_cmd;
  logic [11:0] req_nshot;
  logic [15:0] req_gap, timeout;
  logic [63:0] command;
  logic        cstrobe, meas_done, meas_resultx, meas_resulty, meas_collision;
  logic [31:0] meas_xacc, meas_yacc;
  logic        rsp_valid, rsp_ready;
  logic [11:0] rsp_xones, rsp_yones, rsp_nshot;
  logic [31:0] rsp_xacc, rsp_yacc;
  logic [1:0]  rsp_err;
  logic        busy;

  meas_shot_sched #(.CNT_W(12), .TMO_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_nshot(req_nshot), .req_gap(req_gap), .timeout(timeout),
    .command(command), .cstrobe(cstrobe),
    .meas_done(meas_done), .meas_resultx(meas_resultx), .meas_resulty(meas_resulty),
    .meas_xacc(meas_xacc), .meas_yacc(meas_yacc), .meas_collision(meas_collision),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_xones(rsp_xones), .rsp_yones(rsp_yones), .rsp_nshot(rsp_nshot),
    .rsp_xacc(rsp_xacc), .rsp_yacc(rsp_yacc), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc names the cycle that began at edge cyc.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-shot channel behaviour: latency 0 means done never arrives.
  int          lat[8];
  int          coll[8];
  bit          rx[8], ry[8];
  logic [31:0] xa[8], ya[8];
  int          cs_q[$];
  logic [63:0] cur_cmd;

  // Reference expectations.
  int          exp_cs[$];
  int          e_rc;
  logic [11:0] e_xo, e_yo, e_n;
  logic [1:0]  e_err;
  logic [31:0] e_xa, e_ya;

  // Channel responder: done after the shot latency, decisions one cycle
  // later (inverted during the done cycle), optional collision pulse.
  initial begin : channel
    int idx, cur, dcnt, ccnt;
    bit rpend;
    idx = 0; cur = 0; dcnt = 0; ccnt = 0; rpend = 0;
    meas_done = 0; meas_resultx = 0; meas_resulty = 0; meas_collision = 0;
    meas_xacc = 0; meas_yacc = 0;
    forever begin
      @(negedge clk);
      meas_done = 0; meas_collision = 0; meas_resultx = 0; meas_resulty = 0;
      meas_xacc = $urandom; meas_yacc = $urandom;
      if (!busy) begin idx = 0; dcnt = 0; ccnt = 0; rpend = 0; end
      if (rpend) begin meas_resultx = rx[cur]; meas_resulty = ry[cur]; rpend = 0; end
      if (ccnt > 0) begin ccnt--; if (ccnt == 0) meas_collision = 1; end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          meas_done = 1; meas_xacc = xa[cur]; meas_yacc = ya[cur];
          meas_resultx = !rx[cur]; meas_resulty = !ry[cur]; rpend = 1;
        end
      end
      if (cstrobe) begin
        cs_q.push_back(cyc);
        if (idx < 8) begin cur = idx; dcnt = lat[idx]; ccnt = coll[idx]; end
        idx++;
      end
    end
  end

  // Shot-level model: each completed shot costs latency + 2 cycles plus the
  // gap before the next strobe; a missing or too-late done ends the request
  // timeout + 1 cycles after that shot's strobe.
  task automatic model_req(input int n_in, input int g, input int t, input int acc);
    int c, n;
    exp_cs.delete();
    e_xo = 0; e_yo = 0; e_n = 0; e_err = 0; e_xa = 0; e_ya = 0; e_rc = 0;
    n = (n_in == 0) ? 1 : n_in;
    c = acc;
    for (int i = 0; i < n; i++) begin
      exp_cs.push_back(c);
      if (coll[i] != 0) e_err[1] = 1'b1;
      if (lat[i] == 0 || (t != 0 && lat[i] > t)) begin
        e_err[0] = 1'b1; e_rc = c + t + 1;
        break;
      end
      e_xo += 12'(rx[i]); e_yo += 12'(ry[i]); e_n += 12'd1;
      e_xa = xa[i]; e_ya = ya[i];
      e_rc = c + lat[i] + 2;
      c = e_rc + g;
    end
  endtask

  function automatic bit cs_match();
    if (cs_q.size() != exp_cs.size()) return 1'b0;
    foreach (cs_q[i]) if (cs_q[i] != exp_cs[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic issue_req(input int n, input int g, input int t, output int acc, output bit ok);
    @(negedge clk);
    req_valid = 1; req_cmd = {$urandom, $urandom};
    req_nshot = 12'(n); req_gap = 16'(g); timeout = 16'(t);
    cur_cmd = req_cmd; cs_q.delete();
    ok = 0; acc = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (k > 0) @(negedge clk);
      if (req_ready) begin ok = 1; acc = cyc + 1; end
    end
    @(negedge clk);
    req_valid = 0; req_cmd = {$urandom, $urandom};
    req_nshot = 12'($urandom); req_gap = 16'($urandom);
  endtask

  task automatic wait_rsp(output int rc, output bit ok);
    ok = 0; rc = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      if (rsp_valid) begin ok = 1; rc = cyc; end
      else @(negedge clk);
    end
  endtask

  task automatic handshake(output int h);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    h = cyc;
  endtask

  task automatic fill_shots(input int lo, input int hi);
    for (int i = 0; i < 8; i++) begin
      lat[i] = int'($urandom_range(hi, lo)); coll[i] = 0;
      rx[i] = 1'($urandom); ry[i] = 1'($urandom);
      xa[i] = $urandom; ya[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, cstrobe, rsp_valid, busy} !== 4'b0 ||
        {command, rsp_xones, rsp_yones, rsp_nshot, rsp_xacc, rsp_yacc, rsp_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: ready/cstrobe/valid/busy=%b command=%h rsp_err=%b required all 0",
                        {req_ready, cstrobe, rsp_valid, busy}, command, rsp_err);
    end
    reset = 0; #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_release_ready: got %b required 0", req_ready); end
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL ready_after_release: ready/busy=%b required 10", {req_ready, busy}); end
  endtask

  task automatic test_basic();
    int acc, rc, h; bit ok;
    fill_shots(20, 20);
    rx[0] = 1; rx[1] = 0; rx[2] = 1; rx[3] = 1;
    for (int i = 0; i < 8; i++) ry[i] = 0;
    issue_req(4, 0, 0, acc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_accept: req_ready never 1, required 1"); end
    n_cmp++; if ({cstrobe, busy} !== 2'b11) begin n_bad++; $display("FAIL basic_first_strobe: cstrobe/busy=%b required 11", {cstrobe, busy}); end
    model_req(4, 0, 0, acc);
    wait_rsp(rc, ok);
    n_cmp++; if (!ok || rc != e_rc) begin n_bad++; $display("FAIL basic_rsp_time: rsp_valid at %0d (seen=%0d) required %0d", rc, ok, e_rc); end
    n_cmp++;
    if ({rsp_xones, rsp_yones, rsp_nshot, rsp_err} !== {12'd3, 12'd0, 12'd4, 2'b00}) begin
      n_bad++; $display("FAIL basic_fields: x=%0d y=%0d n=%0d err=%b required x=3 y=0 n=4 err=00", rsp_xones, rsp_yones, rsp_nshot, rsp_err);
    end
    n_cmp++; if ({rsp_xacc, rsp_yacc} !== {e_xa, e_ya}) begin n_bad++; $display("FAIL basic_acc: %h/%h required %h/%h", rsp_xacc, rsp_yacc, e_xa, e_ya); end
    n_cmp++;
    if (!cs_match()) begin
      n_bad++; $display("FAIL basic_strobes: %0d strobes spacing %0d required %0d strobes spacing 22",
                        cs_q.size(), (cs_q.size() > 1) ? cs_q[1] - cs_q[0] : -1, exp_cs.size());
    end
    n_cmp++; if (command !== cur_cmd) begin n_bad++; $display("FAIL basic_command: %h required %h", command, cur_cmd); end
    handshake(h);
    n_cmp++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin n_bad++; $display("FAIL basic_after_hs: valid/ready/busy=%b required 010", {rsp_valid, req_ready, busy}); end
  endtask

  task automatic test_nshot_zero();
    int acc, rc, h; bit ok;
    fill_shots(1, 30);
    xa[0] = 32'h0001_2345;
    issue_req(0, 5, 0, acc, ok);
    model_req(0, 5, 0, acc);
    wait_rsp(rc, ok);
    n_cmp++; if (!ok || rc != e_rc) begin n_bad++; $display("FAIL zero_rsp_time: %0d (seen=%0d) required %0d", rc, ok, e_rc); end
    n_cmp++; if (cs_q.size() != 1 || rsp_nshot !== 12'd1) begin n_bad++; $display("FAIL zero_one_shot: strobes=%0d nshot=%0d required 1/1", cs_q.size(), rsp_nshot); end
    n_cmp++; if (rsp_xacc !== 32'h0001_2345 || rsp_yacc !== e_ya) begin n_bad++; $display("FAIL zero_acc: %h/%h required 00012345/%h", rsp_xacc, rsp_yacc, e_ya); end
    handshake(h);
  endtask

  task automatic test_timeout();
    int acc, rc, h; bit ok;
    fill_shots(1, 5);
    lat[0] = 15;
    issue_req(1, 0, 10, acc, ok);
    wait_rsp(rc, ok);
    n_cmp++; if (!ok || rc != acc + 11) begin n_bad++; $display("FAIL tmo_rsp_time: %0d (seen=%0d) required %0d", rc, ok, acc + 11); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_nshot, rsp_xones, rsp_yones, rsp_xacc} !== {1'b1, 2'b01, 12'd0, 12'd0, 12'd0, 32'd0}) begin
      n_bad++; $display("FAIL tmo_fields_after_late_done: valid=%b err=%b n=%0d x=%0d y=%0d xacc=%h required 1 01 0 0 0 0",
                        rsp_valid, rsp_err, rsp_nshot, rsp_xones, rsp_yones, rsp_xacc);
    end
    handshake(h);
    lat[0] = 10;
    issue_req(1, 0, 10, acc, ok);
    model_req(1, 0, 10, acc);
    wait_rsp(rc, ok);
    n_cmp++;
    if (!ok || rc != e_rc || {rsp_err, rsp_nshot} !== {2'b00, 12'd1}) begin
      n_bad++; $display("FAIL tmo_done_wins: rsp at %0d err=%b n=%0d required %0d 00 1", rc, rsp_err, rsp_nshot, e_rc);
    end
    handshake(h);
  endtask

  task automatic test_collision_gap();
    int acc, rc, h; bit ok;
    fill_shots(3, 15);
    coll[1] = int'($urandom_range(lat[1], 1));
    issue_req(3, 7, 0, acc, ok);
    model_req(3, 7, 0, acc);
    wait_rsp(rc, ok);
    n_cmp++; if (!ok || rc != e_rc) begin n_bad++; $display("FAIL coll_rsp_time: %0d required %0d", rc, e_rc); end
    n_cmp++;
    if ({rsp_nshot, rsp_err, rsp_xones, rsp_yones} !== {12'd3, 2'b10, e_xo, e_yo}) begin
      n_bad++; $display("FAIL coll_fields: n=%0d err=%b x=%0d y=%0d required 3 10 %0d %0d", rsp_nshot, rsp_err, rsp_xones, rsp_yones, e_xo, e_yo);
    end
    n_cmp++;
    if (!cs_match()) begin
      n_bad++; $display("FAIL coll_gap_strobes: %0d strobes, second at %0d required %0d strobes, second at %0d",
                        cs_q.size(), (cs_q.size() > 1) ? cs_q[1] : -1, exp_cs.size(), exp_cs[1]);
    end
    handshake(h);
  endtask

  task automatic test_backpressure();
    int acc, rc, h, g; bit ok;
    logic [63:0] cmd1, cmd2;
    fill_shots(2, 12);
    g = int'($urandom_range(3, 0));
    issue_req(2, g, 0, acc, ok);
    cmd1 = cur_cmd;
    model_req(2, g, 0, acc);
    wait_rsp(rc, ok);
    n_cmp++; if (!ok || rc != e_rc) begin n_bad++; $display("FAIL bp_rsp_time: %0d required %0d", rc, e_rc); end
    req_valid = 1; req_cmd = {$urandom, $urandom}; req_nshot = 12'd1; req_gap = 16'd0; timeout = 16'd0;
    cmd2 = req_cmd;
    for (int k = 0; k < 50; k++) begin
      n_cmp++;
      if ({rsp_valid, req_ready, cstrobe} !== 3'b100 || {rsp_xones, rsp_yones, rsp_nshot, rsp_err} !== {e_xo, e_yo, e_n, e_err} ||
          {rsp_xacc, rsp_yacc} !== {e_xa, e_ya} || command !== cmd1) begin
        n_bad++; $display("FAIL bp_hold cycle %0d: valid/ready/cstrobe=%b x=%0d y=%0d n=%0d err=%b required 100 %0d %0d %0d %b",
                          k, {rsp_valid, req_ready, cstrobe}, rsp_xones, rsp_yones, rsp_nshot, rsp_err, e_xo, e_yo, e_n, e_err);
      end
      @(negedge clk);
    end
    cs_q.delete();
    handshake(h);
    n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_after_hs: valid/ready=%b required 01", {rsp_valid, req_ready}); end
    @(negedge clk);
    n_cmp++;
    if (cstrobe !== 1'b1 || cs_q.size() != 1 || cs_q[0] != h + 1) begin
      n_bad++; $display("FAIL b2b_strobe: cstrobe=%b strobes=%0d required strobe at %0d", cstrobe, cs_q.size(), h + 1);
    end
    req_valid = 0;
    model_req(1, 0, 0, h + 1);
    wait_rsp(rc, ok);
    n_cmp++;
    if (!ok || rc != e_rc || {rsp_nshot, rsp_xones, rsp_yones, rsp_xacc} !== {12'd1, e_xo, e_yo, e_xa} || command !== cmd2) begin
      n_bad++; $display("FAIL b2b_rsp: at %0d n=%0d xacc=%h cmd=%h required %0d 1 %h %h", rc, rsp_nshot, rsp_xacc, command, e_rc, e_xa, cmd2);
    end
    handshake(h);
  endtask

  task automatic test_reset_mid();
    int acc, rc, h, g; bit ok;
    fill_shots(10, 10);
    issue_req(3, 0, 0, acc, ok);
    ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      if (cs_q.size() >= 2) ok = 1; else @(negedge clk);
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_second_strobe: strobes=%0d required 2", cs_q.size()); end
    repeat (3) @(negedge clk);
    reset = 1; #1;
    n_cmp++;
    if ({req_ready, cstrobe, rsp_valid, busy} !== 4'b0 ||
        {command, rsp_xones, rsp_yones, rsp_nshot, rsp_xacc, rsp_yacc, rsp_err} !== '0) begin
      n_bad++; $display("FAIL rmid_async_clear: ready/cstrobe/valid/busy=%b n=%0d command=%h required all 0",
                        {req_ready, cstrobe, rsp_valid, busy}, rsp_nshot, command);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    n_cmp++; if ({req_ready, rsp_valid, busy} !== 3'b100) begin n_bad++; $display("FAIL rmid_ready: ready/valid/busy=%b required 100", {req_ready, rsp_valid, busy}); end
    fill_shots(2, 9);
    g = int'($urandom_range(4, 0));
    issue_req(2, g, 0, acc, ok);
    model_req(2, g, 0, acc);
    wait_rsp(rc, ok);
    n_cmp++;
    if (!ok || rc != e_rc || {rsp_xones, rsp_yones, rsp_nshot, rsp_err} !== {e_xo, e_yo, e_n, e_err} || !cs_match()) begin
      n_bad++; $display("FAIL rmid_clean_run: at %0d x=%0d y=%0d n=%0d err=%b required %0d %0d %0d %0d %b",
                        rc, rsp_xones, rsp_yones, rsp_nshot, rsp_err, e_rc, e_xo, e_yo, e_n, e_err);
    end
    handshake(h);
  endtask

  task automatic test_random();
    int acc, rc, h, n, g, t, w; bit ok;
    for (int it = 0; it < 15; it++) begin
      n = int'($urandom_range(5, 0)); g = int'($urandom_range(4, 0));
      t = ($urandom_range(2, 0) == 0) ? int'($urandom_range(20, 4)) : 0;
      for (int i = 0; i < 8; i++) begin
        lat[i] = int'($urandom_range(25, 1));
        if (t != 0 && $urandom_range(3, 0) == 0) lat[i] = ($urandom_range(1, 0) == 1) ? 0 : t + int'($urandom_range(8, 1));
        rx[i] = 1'($urandom); ry[i] = 1'($urandom); xa[i] = $urandom; ya[i] = $urandom;
        w = (t != 0 && (lat[i] == 0 || lat[i] > t)) ? t : lat[i];
        coll[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(w, 1)) : 0;
      end
      issue_req(n, g, t, acc, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_accept it %0d: req_ready never 1", it); end
      model_req(n, g, t, acc);
      wait_rsp(rc, ok);
      n_cmp++;
      if (!ok || rc != e_rc || {rsp_xones, rsp_yones, rsp_nshot, rsp_err} !== {e_xo, e_yo, e_n, e_err}) begin
        n_bad++; $display("FAIL rand_rsp it %0d: at %0d x=%0d y=%0d n=%0d err=%b required %0d %0d %0d %0d %b",
                          it, rc, rsp_xones, rsp_yones, rsp_nshot, rsp_err, e_rc, e_xo, e_yo, e_n, e_err);
      end
      n_cmp++;
      if ({rsp_xacc, rsp_yacc} !== {e_xa, e_ya} || !cs_match()) begin
        n_bad++; $display("FAIL rand_acc_strobes it %0d: acc %h/%h strobes %0d required %h/%h strobes %0d",
                          it, rsp_xacc, rsp_yacc, cs_q.size(), e_xa, e_ya, exp_cs.size());
      end
      repeat ($urandom_range(3, 0)) @(negedge clk);
      handshake(h);
    end
  endtask

  initial begin
    reset = 1; req_valid = 0; req_cmd = 0; req_nshot = 0; req_gap = 0; timeout = 0; rsp_ready = 0;
    for (int i = 0; i < 8; i++) begin lat[i] = 0; coll[i] = 0; rx[i] = 0; ry[i] = 0; xa[i] = 0; ya[i] = 0; end
    test_reset();
    test_basic();
    test_nshot_zero();
    test_timeout();
    test_collision_gap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
